// File: rtl/processors_top_pkg.sv
// Shared types and constants for the p03 matrix-vector processor.
package fifo_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RES_W   = 20;
  localparam int unsigned DEPTH_A = 64;
  localparam int unsigned DEPTH_B = 8;
  localparam int unsigned DEPTH_R = 8;
  localparam int unsigned N_MAX   = 7;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [RES_W-1:0]  result_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    COMPUTE,
    WRITE,
    DONE
  } state_t;

  // Unsigned multiply-accumulate; the full product is zero-extended, no saturation.
  function automatic result_t mac(input result_t acc, input data_t a, input data_t x);
    logic [2*DATA_W-1:0] prod;
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(x);
    return acc + RES_W'(prod);
  endfunction

endpackage

// File: rtl/processors_top_fifo.sv
// Synchronous circular-buffer FIFO with show-ahead output and count-based flags.
module fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/processors_top.sv
// p03 matrix-vector processor: y = A*x over byte operands, results queued for the UART.
module processors_top
  import fifo_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DATA_W-1:0] uart,
  input  logic          pop_uart,
  input  logic          push_A,
  input  logic          push_B,
  input  logic [2:0]    N,
  output logic          full_A,
  output logic          empty_A,
  output logic [RES_W-1:0] result_uart_w
);

  state_t  state, state_next;
  data_t   dout_a, dout_b;
  result_t dout_r;
  logic    full_b, empty_b, full_r, empty_r;
  logic    pop_a, pop_b, push_r, push_b_gated;
  logic [2:0] n_reg, idx, row, last;
  result_t acc;
  data_t   x_reg [N_MAX];

  assign last         = n_reg - 3'd1;
  assign push_b_gated = push_B && !full_b;
  assign result_uart_w = empty_r ? '0 : dout_r;

  fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH_A)) u_fifo_a (
    .clk(clk), .rst(rst), .push(push_A), .pop(pop_a), .din(uart),
    .dout(dout_a), .full(full_A), .empty(empty_A)
  );

  fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH_B)) u_fifo_b (
    .clk(clk), .rst(rst), .push(push_b_gated), .pop(pop_b), .din(uart),
    .dout(dout_b), .full(full_b), .empty(empty_b)
  );

  fifo #(.WIDTH(RES_W), .DEPTH(DEPTH_R)) u_fifo_r (
    .clk(clk), .rst(rst), .push(push_r), .pop(pop_uart), .din(acc),
    .dout(dout_r), .full(full_r), .empty(empty_r)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and FIFO handshake decode; each busy state stalls on its FIFO.
  always_comb begin
    state_next = state;
    pop_a      = 1'b0;
    pop_b      = 1'b0;
    push_r     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (N != 3'd0)) state_next = LOAD_X;
      end
      LOAD_X: begin
        if (!empty_b) begin
          pop_b = 1'b1;
          if (idx == last) state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (!empty_A) begin
          pop_a = 1'b1;
          if (idx == last) state_next = WRITE;
        end
      end
      WRITE: begin
        if (!full_r) begin
          push_r     = 1'b1;
          state_next = (row == last) ? DONE : COMPUTE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: N capture, x register file, column/row counters and accumulator.
  // idx is shared between LOAD_X and COMPUTE since they never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg <= '0;
      idx   <= '0;
      row   <= '0;
      acc   <= '0;
      for (int unsigned i = 0; i < N_MAX; i++) x_reg[i] <= '0;
    end else begin
      if ((state == IDLE) && start && (N != 3'd0)) begin
        n_reg <= N;
        idx   <= '0;
        row   <= '0;
        acc   <= '0;
      end
      if (pop_b) x_reg[idx] <= dout_b;
      if (pop_a) acc <= mac(acc, dout_a, x_reg[idx]);
      if (pop_a || pop_b) idx <= (idx == last) ? 3'd0 : idx + 3'd1;
      if (push_r) begin
        acc <= '0;
        row <= row + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_processors_top.sv
module tb_processors_top;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  uart = '0;
  logic        pop_uart = 1'b0;
  logic        push_A = 1'b0;
  logic        push_B = 1'b0;
  logic [2:0]  N = '0;
  logic        full_A, empty_A;
  logic [19:0] result_uart_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  processors_top dut (
    .clk(clk), .rst(rst), .start(start), .uart(uart), .pop_uart(pop_uart),
    .push_A(push_A), .push_B(push_B), .N(N),
    .full_A(full_A), .empty_A(empty_A), .result_uart_w(result_uart_w)
  );

  typedef struct {
    int unsigned n;
    logic [7:0]  a [49];
    logic [7:0]  b [7];
    logic [19:0] y [7];
  } vec_t;

  vec_t        vecs [5];
  logic [19:0] exp_y [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input bit a, input bit b, input logic [7:0] v);
    push_A = a; push_B = b; uart = v;
    tick();
    push_A = 1'b0; push_B = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] n);
    N = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_y%0d", name, i), 32'(result_uart_w), 32'(exp_y[i]));
      pop_uart = 1'b1;
      tick();
      pop_uart = 1'b0;
    end
    check({name, "_drained"}, 32'(result_uart_w), 32'd0);
  endtask

  task automatic run_vec(input int k);
    int unsigned n;
    n = vecs[k].n;
    for (int i = 0; i < int'(n * n); i++) push(1'b1, 1'b0, vecs[k].a[i]);
    for (int i = 0; i < int'(n); i++) push(1'b0, 1'b1, vecs[k].b[i]);
    do_start(3'(n));
    repeat (2 * n) tick();
    check($sformatf("v%0d_pre_first", k), 32'(result_uart_w), 32'd0);
    tick();
    check($sformatf("v%0d_first_latency", k), 32'(result_uart_w), 32'(vecs[k].y[0]));
    repeat (n * n) tick();
    check($sformatf("v%0d_empty_A", k), 32'(empty_A), 32'd1);
    for (int i = 0; i < 7; i++) exp_y[i] = vecs[k].y[i];
    drain($sformatf("v%0d", k), int'(n));
  endtask

  initial begin
    // Vector table: hand-computed results.
    vecs[0].n = 2;
    for (int i = 0; i < 49; i++) vecs[0].a[i] = 8'(i + 1);
    vecs[0].b[0] = 8'd5; vecs[0].b[1] = 8'd6;
    vecs[0].y[0] = 20'd17; vecs[0].y[1] = 20'd39;

    vecs[1].n = 5;
    for (int i = 0; i < 49; i++) vecs[1].a[i] = 8'(i + 1);
    for (int i = 0; i < 7; i++)  vecs[1].b[i] = 8'(i + 1);
    vecs[1].y[0] = 20'd55;  vecs[1].y[1] = 20'd130; vecs[1].y[2] = 20'd205;
    vecs[1].y[3] = 20'd280; vecs[1].y[4] = 20'd355;

    vecs[2].n = 1;
    vecs[2].a[0] = 8'd255; vecs[2].b[0] = 8'd255; vecs[2].y[0] = 20'd65025;

    vecs[3].n = 7;
    for (int i = 0; i < 49; i++) vecs[3].a[i] = 8'd255;
    for (int i = 0; i < 7; i++) begin
      vecs[3].b[i] = 8'd255;
      vecs[3].y[i] = 20'd455175;
    end

    vecs[4].n = 3;
    for (int i = 0; i < 49; i++) vecs[4].a[i] = 8'(i + 1);
    vecs[4].b[0] = 8'd2; vecs[4].b[1] = 8'd0; vecs[4].b[2] = 8'd1;
    vecs[4].y[0] = 20'd5; vecs[4].y[1] = 20'd14; vecs[4].y[2] = 20'd23;

    // Reset state.
    tick();
    check("rst_empty_A", 32'(empty_A), 32'd1);
    check("rst_full_A", 32'(full_A), 32'd0);
    check("rst_result", 32'(result_uart_w), 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) run_vec(k);

    // push_A and push_B together write the same byte into both FIFOs.
    push(1'b1, 1'b1, 8'd12);
    do_start(3'd1);
    repeat (4) tick();
    check("dual_empty_A", 32'(empty_A), 32'd1);
    exp_y[0] = 20'd144;
    drain("dual", 1);

    // start with N==0 is ignored; data stays queued for the next start.
    for (int i = 1; i <= 4; i++) push(1'b1, 1'b0, 8'(i));
    push(1'b0, 1'b1, 8'd5);
    push(1'b0, 1'b1, 8'd6);
    do_start(3'd0);
    repeat (10) tick();
    check("n0_empty_A", 32'(empty_A), 32'd0);
    check("n0_result", 32'(result_uart_w), 32'd0);
    do_start(3'd2);
    repeat (9) tick();
    exp_y[0] = 20'd17; exp_y[1] = 20'd39;
    drain("n0_then2", 2);

    // Fill A: 64 pushes -> full, 65th (value 9) dropped.
    do_reset();
    for (int i = 0; i < 64; i++) push(1'b1, 1'b0, 8'd1);
    check("fill_full_A", 32'(full_A), 32'd1);
    push(1'b1, 1'b0, 8'd9);
    check("fill_full_A_65", 32'(full_A), 32'd1);
    for (int i = 0; i < 7; i++) push(1'b0, 1'b1, 8'd1);
    do_start(3'd7);
    repeat (64) tick();
    check("fill_after7_full", 32'(full_A), 32'd0);
    check("fill_after7_empty", 32'(empty_A), 32'd0);
    for (int i = 0; i < 7; i++) exp_y[i] = 20'd7;
    drain("fill7", 7);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 8'd1);
    do_start(3'd3);
    repeat (16) tick();
    for (int i = 0; i < 3; i++) exp_y[i] = 20'd3;
    drain("fill3", 3);
    for (int i = 0; i < 2; i++) push(1'b0, 1'b1, 8'd1);
    do_start(3'd2);
    repeat (9) tick();
    exp_y[0] = 20'd2; exp_y[1] = 20'd2;
    drain("fill2", 2);
    push(1'b0, 1'b1, 8'd5);
    do_start(3'd1);
    repeat (4) tick();
    check("fill_one_left", 32'(empty_A), 32'd0);
    exp_y[0] = 20'd5;
    drain("fill1a", 1);
    push(1'b0, 1'b1, 8'd5);
    do_start(3'd1);
    repeat (4) tick();
    check("fill_all_used", 32'(empty_A), 32'd1);
    drain("fill1b", 1);

    // FIFO B empty: stall in LOAD_X; a second start while busy is ignored.
    for (int i = 1; i <= 4; i++) push(1'b1, 1'b0, 8'(i));
    do_start(3'd2);
    repeat (5) tick();
    do_start(3'd1);
    repeat (15) tick();
    check("stall_empty_A", 32'(empty_A), 32'd0);
    check("stall_result", 32'(result_uart_w), 32'd0);
    push(1'b0, 1'b1, 8'd5);
    push(1'b0, 1'b1, 8'd6);
    repeat (9) tick();
    check("stall_done_empty_A", 32'(empty_A), 32'd1);
    exp_y[0] = 20'd17; exp_y[1] = 20'd39;
    drain("stall", 2);

    // Reset during COMPUTE aborts and empties everything.
    for (int i = 1; i <= 25; i++) push(1'b1, 1'b0, 8'(i));
    for (int i = 1; i <= 5; i++)  push(1'b0, 1'b1, 8'(i));
    do_start(3'd5);
    repeat (8) tick();
    rst = 1'b1;
    #2;
    check("abort_empty_A", 32'(empty_A), 32'd1);
    check("abort_result", 32'(result_uart_w), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
